burst_write_pipeline: RTL and testbench

Burst write front end: accepts a burst request (start address and length) on an address channel and the matching write-data beats on a separate data channel. It pairs each data beat with its incremented beat address and pushes it through a single registered write stage (T1). It emits one per-beat write response, the beat address, on a valid/ready downstream port. It sits between an upstream burst master and a write sink/response consumer, and exposes the T1 stage on debug ports.

---
 rtl/burst_write_pipeline.sv | 157 +++++++++++++++
 tb/tb_burst_write_pipeline.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_write_pipeline.sv
`default_nettype none
// ============================================================================
// Module   : burst_write_pipeline
// Brief    : Burst write front end. Accepts a burst request (start address,
//            length) on the address channel, then pairs each write-data beat
//            with its incremented beat address and pushes it through one
//            registered write stage (T1). Each beat produces a response equal
//            to its beat address on a valid/ready downstream port.
// Ports    : clk, rst_n          - clock, asynchronous active-low reset
//            u_addr/u_length/u_addr_valid/u_addr_ready - burst request channel
//            u_data/u_data_valid/u_data_ready          - write data channel
//            d_response/d_valid/d_ready                - per-beat response port
//            test_t1_*/test_d_ready                    - T1 stage debug taps
// Revision : 1.0 - initial release
// ============================================================================
module burst_write_pipeline #(
    parameter int DATA_WIDTH       = 32,
    parameter int ADDR_WIDTH       = 32,
    parameter int MAX_BURST_LENGTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] u_addr,
    input  logic [7:0]            u_length,
    input  logic                  u_addr_valid,
    output logic                  u_addr_ready,
    input  logic [DATA_WIDTH-1:0] u_data,
    input  logic                  u_data_valid,
    output logic                  u_data_ready,
    output logic [ADDR_WIDTH-1:0] d_response,
    output logic                  d_valid,
    input  logic                  d_ready,
    output logic [ADDR_WIDTH-1:0] test_t1_addr,
    output logic [DATA_WIDTH-1:0] test_t1_data,
    output logic                  test_t1_we,
    output logic                  test_t1_valid,
    output logic                  test_t1_last,
    output logic                  test_d_ready
);

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_busy = 1'b1;

    // Largest "beats minus one" value a single burst may carry.
    localparam logic [7:0] c_max_rem = 8'(MAX_BURST_LENGTH - 1);

    logic [0:0]            r_state;
    logic [0:0]            w_state_next;
    logic [ADDR_WIDTH-1:0] r_beat_addr;
    logic [7:0]            r_remaining;
    logic [7:0]            w_rem_load;

    logic [ADDR_WIDTH-1:0] r_t1_addr;
    logic [DATA_WIDTH-1:0] r_t1_data;
    logic                  r_t1_we;
    logic                  r_t1_valid;
    logic                  r_t1_last;

    logic                  w_adv;
    logic                  w_addr_hs;
    logic                  w_data_hs;

    // T1 may take a new beat when it is empty or its response drains now.
    assign w_adv      = d_ready || !r_t1_valid;
    assign w_addr_hs  = u_addr_valid && u_addr_ready;
    assign w_data_hs  = u_data_valid && u_data_ready;
    assign w_rem_load = (u_length > c_max_rem) ? c_max_rem : u_length;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: if (w_addr_hs) w_state_next = c_st_busy;
            c_st_busy: if (w_data_hs && (r_remaining == 8'd0)) w_state_next = c_st_idle;
            default:   w_state_next = c_st_idle;
        endcase
    end

    // ------------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------------
    always_comb begin
        u_addr_ready = 1'b0;
        u_data_ready = 1'b0;
        case (r_state)
            c_st_idle: u_addr_ready = 1'b1;
            c_st_busy: u_data_ready = w_adv;
            default: begin
                u_addr_ready = 1'b0;
                u_data_ready = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Beat address / remaining counter and the T1 write stage
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat_addr <= '0;
            r_remaining <= '0;
            r_t1_addr   <= '0;
            r_t1_data   <= '0;
            r_t1_we     <= 1'b0;
            r_t1_valid  <= 1'b0;
            r_t1_last   <= 1'b0;
        end else begin
            if (w_addr_hs) begin
                r_beat_addr <= u_addr;
                r_remaining <= w_rem_load;
            end

            if (w_data_hs) begin
                r_t1_addr   <= r_beat_addr;
                r_t1_data   <= u_data;
                r_t1_we     <= 1'b1;
                r_t1_valid  <= 1'b1;
                r_t1_last   <= (r_remaining == 8'd0);
                // Full-width increment: wraps modulo 2^ADDR_WIDTH.
                r_beat_addr <= r_beat_addr + 1'b1;
                // The last beat leaves the counter at zero for the next load.
                if (r_remaining != 8'd0) begin
                    r_remaining <= r_remaining - 8'd1;
                end
            end else if (w_adv) begin
                // Drained with nothing behind it: empty T1, keep addr/data.
                r_t1_we    <= 1'b0;
                r_t1_valid <= 1'b0;
                r_t1_last  <= 1'b0;
            end
        end
    end

    assign d_valid       = r_t1_valid;
    assign d_response    = r_t1_addr;
    assign test_t1_addr  = r_t1_addr;
    assign test_t1_data  = r_t1_data;
    assign test_t1_we    = r_t1_we;
    assign test_t1_valid = r_t1_valid;
    assign test_t1_last  = r_t1_last;
    assign test_d_ready  = d_ready;

endmodule
`default_nettype wire

// File: tb/tb_burst_write_pipeline.sv
`default_nettype none
// ============================================================================
// Module   : tb_burst_write_pipeline
// Brief    : Self-checking bench for burst_write_pipeline. Directed bursts with
//            hand-computed responses, plus a long bubble/stall sweep whose
//            expected responses are base+j for every burst.
// Revision : 1.0 - initial release
// ============================================================================
module tb_burst_write_pipeline;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 32;
    localparam int TIMEOUT    = 200;

    logic                  clk;
    logic                  rst_n;
    logic [ADDR_WIDTH-1:0] u_addr;
    logic [7:0]            u_length;
    logic                  u_addr_valid;
    logic                  u_addr_ready;
    logic [DATA_WIDTH-1:0] u_data;
    logic                  u_data_valid;
    logic                  u_data_ready;
    logic [ADDR_WIDTH-1:0] d_response;
    logic                  d_valid;
    logic                  d_ready;
    logic [ADDR_WIDTH-1:0] test_t1_addr;
    logic [DATA_WIDTH-1:0] test_t1_data;
    logic                  test_t1_we;
    logic                  test_t1_valid;
    logic                  test_t1_last;
    logic                  test_d_ready;

    logic                  d_ready_req;
    logic                  rand_ready;
    logic                  rand_en;

    int                    checks;
    int                    errors;

    // Expected responses in order: {last, addr}.
    logic [ADDR_WIDTH:0]   exp_q[$];

    assign d_ready = rand_en ? rand_ready : d_ready_req;

    burst_write_pipeline #(
        .DATA_WIDTH      (DATA_WIDTH),
        .ADDR_WIDTH      (ADDR_WIDTH),
        .MAX_BURST_LENGTH(4)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .u_addr       (u_addr),
        .u_length     (u_length),
        .u_addr_valid (u_addr_valid),
        .u_addr_ready (u_addr_ready),
        .u_data       (u_data),
        .u_data_valid (u_data_valid),
        .u_data_ready (u_data_ready),
        .d_response   (d_response),
        .d_valid      (d_valid),
        .d_ready      (d_ready),
        .test_t1_addr (test_t1_addr),
        .test_t1_data (test_t1_data),
        .test_t1_we   (test_t1_we),
        .test_t1_valid(test_t1_valid),
        .test_t1_last (test_t1_last),
        .test_d_ready (test_d_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    // Random downstream stalls: ready low for runs of roughly 0-2 cycles.
    initial rand_ready = 1'b1;
    always @(posedge clk) begin
        #1 rand_ready = ($urandom_range(0, 2) != 0);
    end

    // Response monitor: inputs change only just after posedge, so the
    // negedge view is exactly what the next edge will see.
    always @(negedge clk) begin
        if (rst_n && d_valid && d_ready) begin
            check("resp_avail", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                check("resp", 64'({test_t1_last, d_response}), 64'(exp_q.pop_front()));
                check("resp_we", 64'(test_t1_we), 64'd1);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_addr(input logic [ADDR_WIDTH-1:0] a, input logic [7:0] len);
        int n;
        u_addr       = a;
        u_length     = len;
        u_addr_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!u_addr_ready && n < TIMEOUT) begin
            n++;
            @(negedge clk);
        end
        if (n >= TIMEOUT) check("addr_timeout", 64'(u_addr_ready), 64'd1);
        @(posedge clk);
        #1;
        u_addr_valid = 1'b0;
    endtask

    task automatic send_data(input logic [DATA_WIDTH-1:0] d);
        int n;
        u_data       = d;
        u_data_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!u_data_ready && n < TIMEOUT) begin
            n++;
            @(negedge clk);
        end
        if (n >= TIMEOUT) check("data_timeout", 64'(u_data_ready), 64'd1);
        @(posedge clk);
        #1;
        u_data_valid = 1'b0;
    endtask

    task automatic push_burst(input logic [ADDR_WIDTH-1:0] base, input int beats);
        for (int j = 0; j < beats; j++) begin
            exp_q.push_back({(j == beats - 1), base + ADDR_WIDTH'(j)});
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < TIMEOUT) begin
            n++;
            idle(1);
        end
        check(tag, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rand_en      = 1'b0;
        d_ready_req  = 1'b1;
        rst_n        = 1'b0;
        u_addr       = '0;
        u_length     = '0;
        u_addr_valid = 1'b0;
        u_data       = '0;
        u_data_valid = 1'b0;

        // ---------------- reset state ----------------
        #12;
        check("rst_d_valid",    64'(d_valid),       64'd0);
        check("rst_d_response", 64'(d_response),    64'd0);
        check("rst_t1_data",    64'(test_t1_data),  64'd0);
        check("rst_t1_we_last", 64'({test_t1_we, test_t1_last}), 64'd0);
        check("rst_u_data_rdy", 64'(u_data_ready),  64'd0);
        check("rst_u_addr_rdy", 64'(u_addr_ready),  64'd1);
        check("rst_test_d_rdy", 64'(test_d_ready),  64'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);

        // ---------------- single beat ----------------
        push_burst(32'h10, 1);
        send_addr(32'h10, 8'd0);
        check("single_busy_rdy", 64'(u_addr_ready), 64'd0);
        send_data(32'h10);
        check("single_valid", 64'(d_valid),      64'd1);
        check("single_resp",  64'(d_response),   64'h10);
        check("single_last",  64'(test_t1_last), 64'd1);
        check("single_data",  64'(test_t1_data), 64'h10);
        check("single_idle",  64'(u_addr_ready), 64'd1);
        drain("single_drain");

        // ---------------- 4-beat back-to-back ----------------
        push_burst(32'h20, 4);
        send_addr(32'h20, 8'd3);
        for (int j = 0; j < 4; j++) begin
            send_data(32'h20 + j);
            check("b2b_resp", 64'(d_response),   64'(32'h20 + j));
            check("b2b_last", 64'(test_t1_last), 64'(j == 3));
        end
        drain("b2b_drain");

        // ---------------- backpressure ----------------
        push_burst(32'h30, 4);
        send_addr(32'h30, 8'd3);
        send_data(32'hA0);
        send_data(32'hA1);
        d_ready_req  = 1'b0;
        u_data       = 32'hA2;
        u_data_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("bp_resp",     64'(d_response),   64'h31);
            check("bp_valid",    64'(d_valid),      64'd1);
            check("bp_data",     64'(test_t1_data), 64'hA1);
            check("bp_data_rdy", 64'(u_data_ready), 64'd0);
        end
        @(posedge clk);
        #1 d_ready_req = 1'b1;
        send_data(32'hA2);
        send_data(32'hA3);
        drain("bp_drain");

        // ---------------- address wrap ----------------
        push_burst(32'hFFFF_FFFE, 4);
        send_addr(32'hFFFF_FFFE, 8'd3);
        for (int j = 0; j < 4; j++) send_data(32'hB0 + j);
        drain("wrap_drain");

        // ---------------- truncation, excess beat goes to next burst ----------------
        push_burst(32'h60, 4);
        send_addr(32'h60, 8'd7);
        for (int j = 0; j < 4; j++) send_data(32'hC0 + j);
        check("trunc_last", 64'(test_t1_last), 64'd1);
        check("trunc_idle", 64'(u_addr_ready), 64'd1);
        u_data       = 32'h99;
        u_data_valid = 1'b1;
        @(negedge clk);
        check("idle_no_data", 64'(u_data_ready), 64'd0);
        @(posedge clk);
        #1;
        push_burst(32'h70, 1);
        send_addr(32'h70, 8'd0);
        send_data(32'h99);
        check("excess_data", 64'(test_t1_data), 64'h99);
        drain("trunc_drain");

        // ---------------- reset mid-burst ----------------
        push_burst(32'h50, 4);
        send_addr(32'h50, 8'd3);
        send_data(32'hD0);
        send_data(32'hD1);
        rst_n = 1'b0;
        #1;
        check("mrst_d_valid",  64'(d_valid),       64'd0);
        check("mrst_addr_rdy", 64'(u_addr_ready),  64'd1);
        check("mrst_t1",       64'({test_t1_valid, test_t1_we, test_t1_last}), 64'd0);
        exp_q.delete();
        idle(2);
        rst_n = 1'b1;
        idle(1);
        push_burst(32'h40, 4);
        send_addr(32'h40, 8'd3);
        for (int j = 0; j < 4; j++) send_data(32'hE0 + j);
        drain("mrst_drain");

        // ---------------- bubbles and random stalls ----------------
        rand_en = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            int beats;
            beats = $urandom_range(1, 4);
            push_burst(ADDR_WIDTH'(i * 16), beats);
            idle($urandom_range(0, 2));
            send_addr(ADDR_WIDTH'(i * 16), 8'(beats - 1));
            for (int j = 0; j < beats; j++) begin
                idle($urandom_range(0, 2));
                send_data(DATA_WIDTH'($urandom));
            end
        end
        drain("rand_drain");
        rand_en = 1'b0;
        idle(2);
        check("final_idle", 64'({u_addr_ready, d_valid}), 64'b10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
